// File: rtl/video_decimate_nxm_pkg.sv
// Shared definitions for the runtime-configurable NxM video decimator:
// default decimation limit, shift-width derivation, channel slicing and
// the horizontal mode encoding.
package video_decim_pkg;

    localparam int MAX_SHIFT_DEF = 3;

    typedef enum logic {
        MODE_SKIP = 1'b0,
        MODE_AVG  = 1'b1
    } mode_e;

    // Smallest shift-input width that can express every value up to max_shift
    function automatic int shift_w_for(input int max_shift);
        return (max_shift < 1) ? 1 : $clog2(max_shift + 1);
    endfunction

    // LSB position of channel ch on a packed pixel bus (channel 0 in the LSBs)
    function automatic int ch_lsb(input int ch, input int data_w);
        return ch * data_w;
    endfunction

endpackage

// File: rtl/video_decimate_nxm_acc_ch.sv
// One colour channel of the horizontal box-average: running accumulator
// plus the half-up rounded, shifted group result.
module decim_acc_ch #(
    parameter int DATA_W    = 8,
    parameter int MAX_SHIFT = 3,
    parameter int SHIFT_W   = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               de_i,
    input  logic               first_i,
    input  logic [SHIFT_W-1:0] h_shift_i,
    input  logic [DATA_W-1:0]  data_i,
    output logic [DATA_W-1:0]  avg_o
);

    localparam int ACC_W = DATA_W + MAX_SHIFT;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   rnd;
    logic [ACC_W:0]   sum;

    // Group sum including the current pixel; phase 0 ignores any stale
    // accumulator so an abandoned partial group never leaks into the next one.
    always_comb begin
        base  = first_i ? '0 : acc_q;
        rnd   = (ACC_W+1)'((32'd1 << h_shift_i) >> 1);
        sum   = (ACC_W+1)'(base) + (ACC_W+1)'(data_i) + rnd;
        avg_o = DATA_W'(sum >> h_shift_i);
        acc_d = acc_q;
        if (de_i) begin
            acc_d = first_i ? ACC_W'(data_i) : acc_q + ACC_W'(data_i);
        end
    end

    // Accumulator register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/video_decimate_nxm.sv
// Runtime-configurable video decimator: horizontal skip or box-average by
// 2^h_shift, vertical line-skip by 2^v_shift, fixed one-cycle latency.
// Configuration is only taken on the vs rising edge so a frame never mixes
// two decimation factors.
module video_decimate_nxm
    import video_decim_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CH        = 3,
    parameter int MAX_SHIFT = MAX_SHIFT_DEF,
    parameter int SHIFT_W   = shift_w_for(MAX_SHIFT)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 vs_i,
    input  logic                 hs_i,
    input  logic                 de_i,
    input  logic [CH*DATA_W-1:0] data_i,
    input  logic [SHIFT_W-1:0]   h_shift_i,
    input  logic [SHIFT_W-1:0]   v_shift_i,
    input  logic                 avg_en_i,
    output logic                 vs_o,
    output logic                 hs_o,
    output logic                 de_o,
    output logic [CH*DATA_W-1:0] data_o
);

    localparam int PIX_W = CH * DATA_W;

    logic                 vs_dly_q, vs_dly_d;
    logic                 hs_dly_q, hs_dly_d;
    logic                 de_dly_q, de_dly_d;
    logic                 de_o_q, de_o_d;
    logic [PIX_W-1:0]     data_o_q, data_o_d;
    logic [SHIFT_W-1:0]   h_shift_q, h_shift_d;
    logic [SHIFT_W-1:0]   v_shift_q, v_shift_d;
    mode_e                mode_q, mode_d;
    logic [MAX_SHIFT-1:0] pix_phase_q, pix_phase_d;
    logic [MAX_SHIFT-1:0] line_phase_q, line_phase_d;

    logic [MAX_SHIFT-1:0] h_mask;
    logic [MAX_SHIFT-1:0] v_mask;
    logic                 vs_rise;
    logic                 de_fall;
    logic                 pix_first;
    logic                 pix_last;
    logic                 line_kept;
    logic                 emit;
    logic [PIX_W-1:0]     avg_bus;

    function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s);
        if (int'(s) > MAX_SHIFT) begin
            return SHIFT_W'(MAX_SHIFT);
        end
        return s;
    endfunction

    assign h_mask    = MAX_SHIFT'((32'd1 << h_shift_q) - 32'd1);
    assign v_mask    = MAX_SHIFT'((32'd1 << v_shift_q) - 32'd1);
    assign vs_rise   = vs_i & ~vs_dly_q;
    assign de_fall   = de_dly_q & ~de_i;
    assign pix_first = (pix_phase_q == '0);
    assign pix_last  = (pix_phase_q == h_mask);
    assign line_kept = (line_phase_q == '0);

    // One averaging lane per colour channel
    for (genvar c = 0; c < CH; c++) begin : g_ch
        decim_acc_ch #(
            .DATA_W    (DATA_W),
            .MAX_SHIFT (MAX_SHIFT),
            .SHIFT_W   (SHIFT_W)
        ) u_acc (
            .clock     (clock),
            .reset_n   (reset_n),
            .de_i      (de_i),
            .first_i   (pix_first),
            .h_shift_i (h_shift_q),
            .data_i    (data_i[ch_lsb(c, DATA_W) +: DATA_W]),
            .avg_o     (avg_bus[ch_lsb(c, DATA_W) +: DATA_W])
        );
    end

    // Next-state: config capture, pixel/line phase counters, output qualification
    always_comb begin
        vs_dly_d  = vs_i;
        hs_dly_d  = hs_i;
        de_dly_d  = de_i;
        h_shift_d = h_shift_q;
        v_shift_d = v_shift_q;
        mode_d    = mode_q;
        if (vs_rise) begin
            h_shift_d = clamp_shift(h_shift_i);
            v_shift_d = clamp_shift(v_shift_i);
            mode_d    = avg_en_i ? MODE_AVG : MODE_SKIP;
        end

        pix_phase_d = '0;
        if (de_i && !pix_last) begin
            pix_phase_d = pix_phase_q + MAX_SHIFT'(1);
        end

        line_phase_d = line_phase_q;
        if (vs_rise) begin
            line_phase_d = '0;
        end else if (de_fall) begin
            line_phase_d = (line_phase_q == v_mask) ? '0 : line_phase_q + MAX_SHIFT'(1);
        end

        emit     = de_i & line_kept & ((mode_q == MODE_AVG) ? pix_last : pix_first);
        de_o_d   = emit;
        data_o_d = data_o_q;
        if (emit) begin
            data_o_d = (mode_q == MODE_AVG) ? avg_bus : data_i;
        end
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vs_dly_q     <= 1'b0;
            hs_dly_q     <= 1'b0;
            de_dly_q     <= 1'b0;
            de_o_q       <= 1'b0;
            data_o_q     <= '0;
            h_shift_q    <= '0;
            v_shift_q    <= '0;
            mode_q       <= MODE_SKIP;
            pix_phase_q  <= '0;
            line_phase_q <= '0;
        end else begin
            vs_dly_q     <= vs_dly_d;
            hs_dly_q     <= hs_dly_d;
            de_dly_q     <= de_dly_d;
            de_o_q       <= de_o_d;
            data_o_q     <= data_o_d;
            h_shift_q    <= h_shift_d;
            v_shift_q    <= v_shift_d;
            mode_q       <= mode_d;
            pix_phase_q  <= pix_phase_d;
            line_phase_q <= line_phase_d;
        end
    end

    assign vs_o   = vs_dly_q;
    assign hs_o   = hs_dly_q;
    assign de_o   = de_o_q;
    assign data_o = data_o_q;

endmodule

// File: tb/tb_video_decimate_nxm.sv
// Scoreboard bench for video_decimate_nxm: directed and random frames,
// expected pixels computed per line from the decimation rules.
module tb_video_decimate_nxm;

    localparam int DATA_W    = 8;
    localparam int CH        = 3;
    localparam int MAX_SHIFT = 3;
    localparam int SHIFT_W   = 2;
    localparam int PIX_W     = CH * DATA_W;

    logic               clock;
    logic               reset_n;
    logic               vs_i, hs_i, de_i, avg_en_i;
    logic [PIX_W-1:0]   data_i;
    logic [SHIFT_W-1:0] h_shift_i, v_shift_i;
    logic               vs_o, hs_o, de_o;
    logic [PIX_W-1:0]   data_o;

    logic [PIX_W-1:0] exp_q[$];
    logic [PIX_W-1:0] line_pix[64];
    logic [PIX_W-1:0] last_exp;
    logic             vs_prev, hs_prev;
    logic             drain_req;
    int               act_h, act_v, act_avg, row_idx;
    int               checks;
    int               failures;

    video_decimate_nxm #(
        .DATA_W    (DATA_W),
        .CH        (CH),
        .MAX_SHIFT (MAX_SHIFT),
        .SHIFT_W   (SHIFT_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .vs_i      (vs_i),
        .hs_i      (hs_i),
        .de_i      (de_i),
        .data_i    (data_i),
        .h_shift_i (h_shift_i),
        .v_shift_i (v_shift_i),
        .avg_en_i  (avg_en_i),
        .vs_o      (vs_o),
        .hs_o      (hs_o),
        .de_o      (de_o),
        .data_o    (data_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Sync inputs as seen at each active edge, for the 1-cycle delay check
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vs_prev <= 1'b0;
            hs_prev <= 1'b0;
        end else begin
            vs_prev <= vs_i;
            hs_prev <= hs_i;
        end
    end

    // Monitor: reset state, sync delay, scoreboard pops, data hold, drain
    always @(negedge clock) begin
        if (!reset_n) begin
            last_exp = '0;
            checks++;
            if ({vs_o, hs_o, de_o, data_o} !== '0) begin
                failures++;
                $display("[TB] FAIL reset_state: got vs=%b hs=%b de=%b data=%h expected all zero",
                         vs_o, hs_o, de_o, data_o);
            end
        end else begin
            checks++;
            if (vs_o !== vs_prev || hs_o !== hs_prev) begin
                failures++;
                $display("[TB] FAIL sync_delay: got vs=%b hs=%b expected vs=%b hs=%b",
                         vs_o, hs_o, vs_prev, hs_prev);
            end
            if (de_o === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_de: got de_o=1 data=%h expected no output", data_o);
                end else begin
                    last_exp = exp_q.pop_front();
                    if (data_o !== last_exp) begin
                        failures++;
                        $display("[TB] FAIL data_o: got %h expected %h", data_o, last_exp);
                    end
                end
            end else begin
                checks++;
                if (de_o !== 1'b0 || data_o !== last_exp) begin
                    failures++;
                    $display("[TB] FAIL data_hold: got de=%b data=%h expected de=0 data=%h",
                             de_o, data_o, last_exp);
                end
            end
            if (drain_req) begin
                checks++;
                if (exp_q.size() != 0) begin
                    failures++;
                    $display("[TB] FAIL drain: got %0d outputs missing expected 0", exp_q.size());
                    exp_q.delete();
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        de_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            data_i = PIX_W'($urandom);
            tick();
        end
    endtask

    task automatic set_cfg(input int h, input int v, input int avg);
        h_shift_i = SHIFT_W'(h);
        v_shift_i = SHIFT_W'(v);
        avg_en_i  = (avg != 0);
    endtask

    // Frame start: the model adopts whatever config sits on the inputs now
    task automatic vs_pulse();
        vs_i    = 1'b1;
        act_h   = (int'(h_shift_i) > MAX_SHIFT) ? MAX_SHIFT : int'(h_shift_i);
        act_v   = (int'(v_shift_i) > MAX_SHIFT) ? MAX_SHIFT : int'(v_shift_i);
        act_avg = int'(avg_en_i);
        row_idx = 0;
        idle(2);
        vs_i = 1'b0;
        idle(2);
    endtask

    // Reference: expected outputs of one line from group/row arithmetic
    task automatic check_output(input int width);
        int g;
        logic [PIX_W-1:0] px;
        g = 1 << act_h;
        if ((row_idx % (1 << act_v)) != 0) return;
        if (act_avg == 0) begin
            for (int s = 0; s < width; s += g) exp_q.push_back(line_pix[s]);
        end else begin
            for (int s = 0; s + g <= width; s += g) begin
                for (int c = 0; c < CH; c++) begin
                    int sum;
                    sum = 0;
                    for (int k = 0; k < g; k++) sum += int'(line_pix[s+k][c*DATA_W +: DATA_W]);
                    px[c*DATA_W +: DATA_W] = DATA_W'((sum + g / 2) / g);
                end
                exp_q.push_back(px);
            end
        end
    endtask

    task automatic apply_stimulus(input int width);
        check_output(width);
        hs_i = 1'b1;
        idle(2);
        hs_i = 1'b0;
        idle(1);
        for (int i = 0; i < width; i++) begin
            de_i   = 1'b1;
            data_i = line_pix[i];
            tick();
        end
        idle(2);
        row_idx++;
    endtask

    task automatic fill_const(input int width, input logic [DATA_W-1:0] v);
        for (int i = 0; i < width; i++) line_pix[i] = {CH{v}};
    endtask

    task automatic fill_rand(input int width);
        for (int i = 0; i < width; i++) line_pix[i] = PIX_W'($urandom);
    endtask

    task automatic drain();
        idle(3);
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        drain_req = 1'b0;
        exp_q.delete();
        reset_n = 1'b0;
        vs_i = 1'b0;
        hs_i = 1'b0;
        de_i = 1'b1;
        set_cfg(0, 0, 0);
        act_h = 0; act_v = 0; act_avg = 0; row_idx = 0;

        // Reset held with active de: outputs must stay zero
        for (int i = 0; i < 4; i++) begin
            data_i = PIX_W'($urandom);
            tick();
        end
        reset_n = 1'b1;
        de_i = 1'b0;
        idle(2);

        // Passthrough after reset, no frame start seen
        fill_rand(5);
        apply_stimulus(5);
        drain();

        // Skip 2x2 on a 4x4 frame of 10*row+col
        set_cfg(1, 1, 0);
        vs_pulse();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) line_pix[c] = {CH{8'(10 * r + c)}};
            apply_stimulus(4);
        end
        drain();

        // Average 4x1: 10,20,30,41 -> 25
        set_cfg(2, 0, 1);
        vs_pulse();
        line_pix[0] = {CH{8'd10}};
        line_pix[1] = {CH{8'd20}};
        line_pix[2] = {CH{8'd30}};
        line_pix[3] = {CH{8'd41}};
        apply_stimulus(4);
        drain();

        // Partial group, average then skip
        vs_pulse();
        fill_const(6, 8'd8);
        apply_stimulus(6);
        set_cfg(2, 0, 0);
        vs_pulse();
        apply_stimulus(6);
        drain();

        // Mid-frame config change only lands on the next frame
        set_cfg(1, 0, 1);
        vs_pulse();
        fill_rand(16);
        apply_stimulus(16);
        set_cfg(3, 0, 1);
        fill_rand(16);
        apply_stimulus(16);
        vs_pulse();
        fill_rand(16);
        apply_stimulus(16);
        drain();

        // Saturation: all 255 averaged over 8
        vs_pulse();
        fill_const(16, 8'hFF);
        apply_stimulus(16);
        drain();

        // Random frames
        for (int f = 0; f < 10; f++) begin
            set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
            vs_pulse();
            for (int r = 0, nr = int'($urandom_range(1, 6)); r < nr; r++) begin
                int w;
                w = int'($urandom_range(1, 24));
                fill_rand(w);
                apply_stimulus(w);
            end
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
